// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Saturating build: define SERIAL_SUB_SAT_EN.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_if.sv
// Request/result bundle between a requester and serial_sub.
// Saturating build: define SERIAL_SUB_SAT_EN.
interface serial_sub_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             borrow;

  modport master (
    output start,
    output in1,
    output in2,
    input  busy,
    input  done,
    input  out,
    input  borrow
  );

  modport slave (
    input  start,
    input  in1,
    input  in2,
    output busy,
    output done,
    output out,
    output borrow
  );

endinterface

// File: rtl/full_sub_bit.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
// Saturating build: define SERIAL_SUB_SAT_EN.
module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor, LSB first, one bit per cycle.
// Saturating build: define SERIAL_SUB_SAT_EN (negative results clamp to 0).
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic       clk,
  input logic       rst,
  serial_sub_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             borrow_q, borrow_d;

  logic             bit_d;
  logic             bit_bout;
  logic [WIDTH-1:0] nxt;
  logic             last;

  full_sub_bit u_bit (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (c_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Partial difference stays in acc_q so out only changes on completion.
  assign nxt  = {bit_d, acc_q};
  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.in1;
          b_d     = bus.in2;
          c_d     = 1'b0;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = bit_bout;
        acc_d = nxt[WIDTH-1:1];
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          cnt_d    = '0;
          borrow_d = bit_bout;
`ifdef SERIAL_SUB_SAT_EN
          out_d    = bit_bout ? '0 : nxt;
`else
          out_d    = nxt;
`endif
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
    end
  end

  assign bus.busy   = (state_q == CALC);
  assign bus.done   = (state_q == DONE);
  assign bus.out    = out_q;
  assign bus.borrow = borrow_q;

endmodule
